mem_arbiter: RTL and testbench

- Shares one memory port between the core's instruction-fetch requester (ibus) and data-access requester (dbus).
- Sits between the pipeline's fetch/memory stages and the memory interface. Exactly one transaction is outstanding at a time.
- Uses a 3-state FSM. dbus wins by default; a bounded anti-starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic              ireq_valid;
   logic [ADDR_W-1:0] ireq_addr;
   logic              iresp_addr_ok;
   logic              iresp_data_ok;
   logic [31:0]       iresp_data;

   logic              dreq_valid;
   logic [ADDR_W-1:0] dreq_addr;
   logic [2:0]        dreq_size;
   logic [7:0]        dreq_strobe;
   logic [63:0]       dreq_data;
   logic              dresp_addr_ok;
   logic              dresp_data_ok;
   logic [63:0]       dresp_data;

   logic              mreq_valid;
   logic              mreq_is_write;
   logic [ADDR_W-1:0] mreq_addr;
   logic [2:0]        mreq_size;
   logic [7:0]        mreq_strobe;
   logic [63:0]       mreq_data;
   logic              mresp_ready;
   logic [63:0]       mresp_data;

   modport slave (
      input  ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
             mresp_ready, mresp_data,
      output iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data,
             mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );

   modport master (
      output ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
             mresp_ready, mresp_data,
      input  iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data,
             mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between ibus and dbus; dbus-priority with
// bounded ibus starvation. Define MEM_ARBITER_PERF_EN to add grant/busy performance counters.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 64
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_PERF_EN
   ,
   output logic [31:0]   perf_igrant,
   output logic [31:0]   perf_dgrant,
   output logic [31:0]   perf_busy_cycles
`endif
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

   logic [1:0]        state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              own_d_q, own_d_d;       // 1 when dbus owns the current transaction
   logic              is_write_q, is_write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        size_q, size_d;
   logic [7:0]        strobe_q, strobe_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [63:0]       rdata_q, rdata_d;

   logic idle, busy, done, grant_i, grant_d;

   assign idle    = (state_q == S_IDLE) && !reset;
   assign busy    = (state_q == S_BUSY);
   assign done    = (state_q == S_DONE) && !reset;
   assign grant_i = idle && bus.ireq_valid && (!bus.dreq_valid || starve_cnt_q == LIMIT);
   assign grant_d = idle && bus.dreq_valid && !grant_i;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      own_d_d      = own_d_q;
      is_write_d   = is_write_q;
      addr_d       = addr_q;
      size_d       = size_q;
      strobe_d     = strobe_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_i) begin
               state_d      = S_BUSY;
               starve_cnt_d = 4'd0;
               own_d_d      = 1'b0;
               is_write_d   = 1'b0;
               addr_d       = bus.ireq_addr;
               size_d       = 3'd2;
               strobe_d     = 8'd0;
               wdata_d      = 64'd0;
            end else if (grant_d) begin
               state_d      = S_BUSY;
               // Only grants that actually pass over a waiting fetch count toward starvation.
               if (bus.ireq_valid)
                  starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
               else
                  starve_cnt_d = 4'd0;
               own_d_d      = 1'b1;
               is_write_d   = |bus.dreq_strobe;
               addr_d       = bus.dreq_addr;
               size_d       = bus.dreq_size;
               strobe_d     = bus.dreq_strobe;
               wdata_d      = bus.dreq_data;
            end
         end
         S_BUSY: begin
            if (bus.mresp_ready) begin
               state_d = S_DONE;
               rdata_d = bus.mresp_data;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         starve_cnt_q <= 4'd0;
         own_d_q      <= 1'b0;
         is_write_q   <= 1'b0;
         addr_q       <= '0;
         size_q       <= 3'd0;
         strobe_q     <= 8'd0;
         wdata_q      <= 64'd0;
         rdata_q      <= 64'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         own_d_q      <= own_d_d;
         is_write_q   <= is_write_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         strobe_q     <= strobe_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.iresp_addr_ok = grant_i;
   assign bus.dresp_addr_ok = grant_d;

   assign bus.mreq_valid    = busy;
   assign bus.mreq_is_write = busy & is_write_q;
   assign bus.mreq_addr     = busy ? addr_q   : '0;
   assign bus.mreq_size     = busy ? size_q   : 3'd0;
   assign bus.mreq_strobe   = busy ? strobe_q : 8'd0;
   assign bus.mreq_data     = busy ? wdata_q  : 64'd0;

   assign bus.iresp_data_ok = done & !own_d_q;
   assign bus.dresp_data_ok = done &  own_d_q;
   assign bus.iresp_data    = !bus.iresp_data_ok ? 32'd0 :
                              (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]);
   assign bus.dresp_data    = bus.dresp_data_ok ? rdata_q : 64'd0;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] perf_igrant_q, perf_igrant_d;
   logic [31:0] perf_dgrant_q, perf_dgrant_d;
   logic [31:0] perf_busy_q, perf_busy_d;

   always_comb begin
      perf_igrant_d = perf_igrant_q + {31'd0, grant_i};
      perf_dgrant_d = perf_dgrant_q + {31'd0, grant_d};
      perf_busy_d   = perf_busy_q   + {31'd0, busy};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_igrant_q <= 32'd0;
         perf_dgrant_q <= 32'd0;
         perf_busy_q   <= 32'd0;
      end else begin
         perf_igrant_q <= perf_igrant_d;
         perf_dgrant_q <= perf_dgrant_d;
         perf_busy_q   <= perf_busy_d;
      end
   end

   assign perf_igrant      = perf_igrant_q;
   assign perf_dgrant      = perf_dgrant_q;
   assign perf_busy_cycles = perf_busy_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_mem_arbiter;
   localparam int ADDR_W = 64;
   localparam int LIMIT  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] perf_igrant, perf_dgrant, perf_busy_cycles;
`endif

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef MEM_ARBITER_PERF_EN
      ,
      .perf_igrant(perf_igrant),
      .perf_dgrant(perf_dgrant),
      .perf_busy_cycles(perf_busy_cycles)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_quiet();
      bus.ireq_valid = 1'b0; bus.ireq_addr = '0;
      bus.dreq_valid = 1'b0; bus.dreq_addr = '0; bus.dreq_size = 3'd0;
      bus.dreq_strobe = 8'd0; bus.dreq_data = 64'd0;
      bus.mresp_ready = 1'b0; bus.mresp_data = 64'd0;
   endtask

   task automatic test_reset();
      drive_quiet();
      bus.ireq_valid = 1'b1; bus.dreq_valid = 1'b1; bus.mresp_ready = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      sample();
      checks++; if (bus.iresp_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_iaddr_ok: got %b exp 0", bus.iresp_addr_ok); end
      checks++; if (bus.dresp_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_daddr_ok: got %b exp 0", bus.dresp_addr_ok); end
      checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL rst_mreq_valid: got %b exp 0", bus.mreq_valid); end
      checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_ok: got %b%b exp 00", bus.iresp_data_ok, bus.dresp_data_ok); end
      checks++; if (bus.iresp_data !== 32'd0 || bus.dresp_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h %h exp 0", bus.iresp_data, bus.dresp_data); end
      step();
      reset = 1'b0;
      drive_quiet();
   endtask

   task automatic test_single_fetch();
      step();                                   // cycle 0
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0004;
      sample();
      checks++; if (bus.iresp_addr_ok !== 1'b1 || bus.dresp_addr_ok !== 1'b0) begin errors++; $display("FAIL fetch_addr_ok: got i=%b d=%b exp i=1 d=0", bus.iresp_addr_ok, bus.dresp_addr_ok); end
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 3) begin bus.mresp_ready = 1'b1; bus.mresp_data = 64'hAAAA_BBBB_1111_2222; end
         sample();
         checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_size !== 3'd2 || bus.mreq_is_write !== 1'b0 || bus.mreq_addr !== 64'h8000_0004) begin
            errors++; $display("FAIL fetch_busy_c%0d: got v=%b sz=%0d w=%b a=%h exp v=1 sz=2 w=0 a=8000_0004", c, bus.mreq_valid, bus.mreq_size, bus.mreq_is_write, bus.mreq_addr); end
         checks++; if (bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_early_ok_c%0d: got %b exp 0", c, bus.iresp_data_ok); end
      end
      step();                                   // cycle 4
      bus.mresp_ready = 1'b0;
      sample();
      checks++; if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'hAAAA_BBBB) begin errors++; $display("FAIL fetch_data: got ok=%b d=%h exp ok=1 d=aaaabbbb", bus.iresp_data_ok, bus.iresp_data); end
      checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL fetch_done_mreq: got %b exp 0", bus.mreq_valid); end
      step();                                   // cycle 5: idle again, earliest regrant
      bus.ireq_addr = 64'h8000_0000;
      sample();
      checks++; if (bus.iresp_addr_ok !== 1'b1) begin errors++; $display("FAIL fetch_regrant: got %b exp 1", bus.iresp_addr_ok); end
      checks++; if (bus.iresp_data_ok !== 1'b0 || bus.iresp_data !== 32'd0) begin errors++; $display("FAIL fetch_data_zero: got ok=%b d=%h exp 0", bus.iresp_data_ok, bus.iresp_data); end
      step();
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'hAAAA_BBBB_1111_2222;
      step();
      bus.mresp_ready = 1'b0;
      sample();
      checks++; if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h1111_2222) begin errors++; $display("FAIL fetch_low_word: got ok=%b d=%h exp ok=1 d=11112222", bus.iresp_data_ok, bus.iresp_data); end
      step();
      drive_quiet();
   endtask

   task automatic test_starvation();
      string got_s = "", exp_s = "";
      int starve = 0, ng = 0;
      for (int c = 0; c < 80 && ng < 10; c++) begin
         step();
         bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_1000;
         bus.dreq_valid = 1'b1; bus.dreq_addr = {32'd0, $urandom()}; bus.dreq_size = 3'd3;
         bus.dreq_strobe = 8'd0; bus.mresp_ready = 1'b1; bus.mresp_data = {$urandom(), $urandom()};
         sample();
         if (bus.iresp_addr_ok === 1'b1 || bus.dresp_addr_ok === 1'b1) begin
            got_s = {got_s, (bus.iresp_addr_ok === 1'b1) ? "I" : "D"};
            if (starve == LIMIT) begin exp_s = {exp_s, "I"}; starve = 0; end
            else begin exp_s = {exp_s, "D"}; starve = starve + 1; end
            ng++;
         end
      end
      checks++; if (got_s != exp_s || ng != 10) begin errors++; $display("FAIL starve_order: got %s exp %s", got_s, exp_s); end
      drive_quiet();
      bus.mresp_ready = 1'b1;
      repeat (3) step();
      drive_quiet();
   endtask

   task automatic test_write();
      step();
      bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_0100; bus.dreq_size = 3'd3;
      bus.dreq_strobe = 8'h0F; bus.dreq_data = 64'h1234;
      sample();
      checks++; if (bus.dresp_addr_ok !== 1'b1) begin errors++; $display("FAIL wr_addr_ok: got %b exp 1", bus.dresp_addr_ok); end
      for (int c = 1; c <= 2; c++) begin
         step();
         bus.mresp_ready = (c == 2); bus.mresp_data = 64'hDEAD_BEEF_0000_0001;
         sample();
         checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_is_write !== 1'b1 || bus.mreq_strobe !== 8'h0F || bus.mreq_data !== 64'h1234 || bus.mreq_addr !== 64'h8000_0100) begin
            errors++; $display("FAIL wr_busy_c%0d: got v=%b w=%b s=%h d=%h a=%h exp v=1 w=1 s=0f d=1234 a=80000100", c, bus.mreq_valid, bus.mreq_is_write, bus.mreq_strobe, bus.mreq_data, bus.mreq_addr); end
         checks++; if (bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL wr_early_ok_c%0d: got %b exp 0", c, bus.dresp_data_ok); end
      end
      step();
      bus.mresp_ready = 1'b0;
      sample();
      checks++; if (bus.dresp_data_ok !== 1'b1 || bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL wr_data_ok: got d=%b i=%b exp d=1 i=0", bus.dresp_data_ok, bus.iresp_data_ok); end
      step();
      bus.dreq_valid = 1'b0;
      sample();
      checks++; if (bus.dresp_data_ok !== 1'b0 || bus.dresp_data !== 64'd0) begin errors++; $display("FAIL wr_pulse_len: got ok=%b d=%h exp 0", bus.dresp_data_ok, bus.dresp_data); end
      drive_quiet();
   endtask

   task automatic test_spurious_and_drop();
      for (int c = 0; c < 2; c++) begin
         step();
         drive_quiet();
         bus.mresp_ready = 1'b1; bus.mresp_data = {$urandom(), $urandom()};
         sample();
         checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0 || bus.mreq_valid !== 1'b0) begin
            errors++; $display("FAIL spurious_c%0d: got i=%b d=%b v=%b exp 0", c, bus.iresp_data_ok, bus.dresp_data_ok, bus.mreq_valid); end
      end
      step();
      bus.mresp_ready = 1'b0; bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h0000_0040_0000_0104;
      sample();
      checks++; if (bus.iresp_addr_ok !== 1'b1) begin errors++; $display("FAIL drop_addr_ok: got %b exp 1", bus.iresp_addr_ok); end
      step();
      bus.ireq_valid = 1'b0;
      sample();
      checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h0000_0040_0000_0104) begin errors++; $display("FAIL drop_busy: got v=%b a=%h exp v=1 a=0000004000000104", bus.mreq_valid, bus.mreq_addr); end
      step();
      bus.mresp_ready = 1'b1; bus.mresp_data = 64'h5555_6666_7777_8888;
      step();
      bus.mresp_data = 64'h0;                  // ready still high in DONE: must be ignored
      sample();
      checks++; if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h5555_6666) begin errors++; $display("FAIL drop_data: got ok=%b d=%h exp ok=1 d=55556666", bus.iresp_data_ok, bus.iresp_data); end
      step();
      sample();
      checks++; if (bus.iresp_data_ok !== 1'b0 || bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL drop_after: got ok=%b v=%b exp 0 0", bus.iresp_data_ok, bus.mreq_valid); end
      drive_quiet();
   endtask

   task automatic test_reset_mid();
      step();
      bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0200;
      sample();
      checks++; if (bus.iresp_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_addr_ok: got %b exp 1", bus.iresp_addr_ok); end
      step();
      sample();
      checks++; if (bus.mreq_valid !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b exp 1", bus.mreq_valid); end
      step();
      reset = 1'b1; bus.ireq_valid = 1'b0;
      step();
      reset = 1'b0;
      sample();
      checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL rmid_drop: got %b exp 0", bus.mreq_valid); end
      for (int c = 0; c < 3; c++) begin
         step();
         bus.mresp_ready = 1'b1; bus.mresp_data = {$urandom(), $urandom()};
         sample();
         checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0 || bus.mreq_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_no_ok_c%0d: got i=%b d=%b v=%b exp 0", c, bus.iresp_data_ok, bus.dresp_data_ok, bus.mreq_valid); end
      end
      drive_quiet();
   endtask

   // Transaction-level model: phase of the single outstanding transfer, its owner and fields.
   task automatic test_random();
      int ph = 0, starve = 0, err0 = errors;
      bit own_d = 0, iv = 0, dv = 0, iwait = 0, dwait = 0, rdy, exp_ig, exp_dg, exp_iok, exp_dok;
      logic [63:0] ia = '0, da = '0, dd = '0, t_addr = '0, t_wdata = '0, t_rdata = '0, mdata;
      logic [2:0]  dsz = '0, t_size = '0;
      logic [7:0]  dst = '0, t_strb = '0;
      logic [31:0] exp_iw;
      for (int c = 0; c < 800; c++) begin
         step();
         rdy   = (ph == 1) ? ($urandom_range(2) == 0) : ($urandom_range(4) == 0);
         mdata = {$urandom(), $urandom()};
         bus.ireq_valid = iv; bus.ireq_addr = ia;
         bus.dreq_valid = dv; bus.dreq_addr = da; bus.dreq_size = dsz; bus.dreq_strobe = dst; bus.dreq_data = dd;
         bus.mresp_ready = rdy; bus.mresp_data = mdata;
         sample();
         exp_ig  = (ph == 0) && iv && (!dv || starve == LIMIT);
         exp_dg  = (ph == 0) && dv && !exp_ig;
         exp_iok = (ph == 2) && !own_d;
         exp_dok = (ph == 2) && own_d;
         exp_iw  = t_addr[2] ? t_rdata[63:32] : t_rdata[31:0];
         checks++; if (bus.iresp_addr_ok !== exp_ig || bus.dresp_addr_ok !== exp_dg) begin
            errors++; $display("FAIL rnd_grant@%0d: got i=%b d=%b exp i=%b d=%b", c, bus.iresp_addr_ok, bus.dresp_addr_ok, exp_ig, exp_dg); end
         checks++; if (bus.mreq_valid !== (ph == 1)) begin errors++; $display("FAIL rnd_mreq_valid@%0d: got %b exp %b", c, bus.mreq_valid, ph == 1); end
         if (ph == 1) begin
            checks++; if (bus.mreq_addr !== t_addr || bus.mreq_size !== t_size || bus.mreq_strobe !== t_strb || bus.mreq_is_write !== (|t_strb) || (own_d && bus.mreq_data !== t_wdata)) begin
               errors++; $display("FAIL rnd_mreq@%0d: got a=%h sz=%0d s=%h d=%h exp a=%h sz=%0d s=%h d=%h", c, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe, bus.mreq_data, t_addr, t_size, t_strb, t_wdata); end
         end
         checks++; if (bus.iresp_data_ok !== exp_iok || bus.dresp_data_ok !== exp_dok) begin
            errors++; $display("FAIL rnd_data_ok@%0d: got i=%b d=%b exp i=%b d=%b", c, bus.iresp_data_ok, bus.dresp_data_ok, exp_iok, exp_dok); end
         checks++; if (bus.iresp_data !== (exp_iok ? exp_iw : 32'd0)) begin
            errors++; $display("FAIL rnd_idata@%0d: got %h exp %h", c, bus.iresp_data, exp_iok ? exp_iw : 32'd0); end
         if (!exp_dok || t_strb == 8'd0) begin
            checks++; if (bus.dresp_data !== (exp_dok ? t_rdata : 64'd0)) begin
               errors++; $display("FAIL rnd_ddata@%0d: got %h exp %h", c, bus.dresp_data, exp_dok ? t_rdata : 64'd0); end
         end
         if (exp_ig) begin
            ph = 1; own_d = 0; starve = 0;
            t_addr = ia; t_size = 3'd2; t_strb = 8'd0; t_wdata = 64'd0;
            if ($urandom_range(3) == 0) iv = 0;
         end else if (exp_dg) begin
            ph = 1; own_d = 1;
            starve = iv ? ((starve == LIMIT) ? LIMIT : starve + 1) : 0;
            t_addr = da; t_size = dsz; t_strb = dst; t_wdata = dd;
            if ($urandom_range(3) == 0) dv = 0;
         end else if (ph == 1 && rdy) begin
            ph = 2; t_rdata = mdata;
         end else if (ph == 2) begin
            ph = 0;
            if (own_d) begin dv = 0; dwait = 0; end
            else begin iv = 0; iwait = 0; end
         end
         if (!iwait && $urandom_range(2) == 0) begin
            iv = 1; iwait = 1; ia = {$urandom(), $urandom() & 32'hFFFF_FFFC};
         end
         if (!dwait && $urandom_range(1) == 0) begin
            dv = 1; dwait = 1; da = {$urandom(), $urandom()}; dsz = 3'($urandom_range(3));
            dst = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255, 1)); dd = {$urandom(), $urandom()};
         end
         if (errors - err0 > 20) break;
      end
      drive_quiet();
      bus.mresp_ready = 1'b1;
      repeat (3) step();
      drive_quiet();
   endtask

`ifdef MEM_ARBITER_PERF_EN
   task automatic test_perf();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int t = 0; t < 5; t++) begin
         step();
         if (t < 3) begin bus.ireq_valid = 1'b1; bus.ireq_addr = 64'(t * 4); end
         else begin bus.dreq_valid = 1'b1; bus.dreq_addr = 64'(t * 8); bus.dreq_size = 3'd3; end
         step();
         bus.ireq_valid = 1'b0; bus.dreq_valid = 1'b0;
         step();
         bus.mresp_ready = 1'b1;
         step();
         bus.mresp_ready = 1'b0;
      end
      step();
      sample();
      checks++; if (perf_igrant !== 32'd3) begin errors++; $display("FAIL perf_igrant: got %0d exp 3", perf_igrant); end
      checks++; if (perf_dgrant !== 32'd2) begin errors++; $display("FAIL perf_dgrant: got %0d exp 2", perf_dgrant); end
      checks++; if (perf_busy_cycles !== 32'd10) begin errors++; $display("FAIL perf_busy: got %0d exp 10", perf_busy_cycles); end
      drive_quiet();
   endtask
`endif

   initial begin
      drive_quiet();
      test_reset();
      test_single_fetch();
      test_starvation();
      test_write();
      test_spurious_and_drop();
      test_reset_mid();
      test_random();
`ifdef MEM_ARBITER_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
